mux_sel_pipe: RTL and testbench

Parametrised, registered N-input operand-select multiplexer with valid/ready handshaking on every input and on the output. It generalises the team's fixed 16-bit 2:1 select mux to WIDTH bits and NUM_IN sources, adds a one-entry output register, and offers two select modes: direct (external `sel`) and round-robin among valid sources. It sits in the processor datapath wherever several producers share one downstream consumer, such as writeback-source or operand-bus select.

---
 rtl/mux_sel_pipe.sv | 104 ++++++++++
 tb/tb_mux_sel_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_pipe.sv
// Registered N-input select mux with valid/ready on every source and on the output.
// Direct mode follows the external sel; round-robin mode rotates among valid sources.
module mux_sel_pipe #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src
);

    // Handshake: a source transfers on any rising edge where in_valid[i] & in_ready[i];
    // the output word is consumed on any edge where out_valid & out_ready.

    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_src;
    logic [SEL_W-1:0]    r_rr_ptr;

    logic                w_slot;
    logic                w_grant_vld;
    logic [SEL_W-1:0]    w_grant;
    logic [NUM_IN-1:0]   w_in_ready;
    logic                w_xfer;
    logic [WIDTH-1:0]    w_xfer_data;
    logic [SEL_W-1:0]    w_xfer_src;
    logic [SEL_W-1:0]    w_rr_next;

    assign w_slot = !r_out_valid | out_ready;

    // Round-robin scan starting at r_rr_ptr; the first valid source found wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % NUM_IN;
            if (!w_grant_vld && in_valid[idx]) begin
                w_grant_vld = 1'b1;
                w_grant     = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        w_in_ready = '0;
        if (!reset) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (mode)
                    w_in_ready[i] = w_slot & w_grant_vld & (w_grant == SEL_W'(i));
                else
                    w_in_ready[i] = w_slot & (sel == SEL_W'(i));
            end
        end
    end

    // At most one in_ready bit is set, so at most one source can match here.
    always_comb begin
        w_xfer      = 1'b0;
        w_xfer_data = '0;
        w_xfer_src  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (in_valid[i] && w_in_ready[i]) begin
                w_xfer      = 1'b1;
                w_xfer_data = in_data[i*WIDTH +: WIDTH];
                w_xfer_src  = SEL_W'(i);
            end
        end
    end

    assign w_rr_next = (w_grant == SEL_W'(NUM_IN - 1)) ? '0 : w_grant + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_xfer_data;
            r_out_src   <= w_xfer_src;
            if (mode)
                r_rr_ptr <= w_rr_next;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed bench for mux_sel_pipe: a 4-source instance for the main scenarios and
// a 3-source instance for the out-of-range select case.
module tb_mux_sel_pipe;

    logic        clk;
    logic        reset;

    logic        a_mode;
    logic [1:0]  a_sel;
    logic [3:0]  a_in_valid;
    logic [63:0] a_in_data;
    logic [3:0]  a_in_ready;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [15:0] a_out_data;
    logic [1:0]  a_out_src;

    logic        b_mode;
    logic [1:0]  b_sel;
    logic [2:0]  b_in_valid;
    logic [47:0] b_in_data;
    logic [2:0]  b_in_ready;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [15:0] b_out_data;
    logic [1:0]  b_out_src;

    int n_vec;
    int n_fail;

    mux_sel_pipe #(.WIDTH(16), .NUM_IN(4)) dut_a (
        .clk(clk), .reset(reset), .mode(a_mode), .sel(a_sel),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_src(a_out_src)
    );

    mux_sel_pipe #(.WIDTH(16), .NUM_IN(3)) dut_b (
        .clk(clk), .reset(reset), .mode(b_mode), .sel(b_sel),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_src(b_out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] d,
                             input logic [1:0] s);
        check({tag, "_valid"}, 32'(a_out_valid), 32'(v));
        check({tag, "_data"},  32'(a_out_data),  32'(d));
        check({tag, "_src"},   32'(a_out_src),   32'(s));
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        reset = 1'b1;
        a_mode = 1'b0; a_sel = 2'd0; a_in_valid = 4'b0000; a_in_data = '0; a_out_ready = 1'b0;
        b_mode = 1'b0; b_sel = 2'd0; b_in_valid = 3'b000;
        b_in_data = {16'hC002, 16'hC001, 16'hC000}; b_out_ready = 1'b1;

        // Reset held two cycles; in_ready gated even though direct sel=0 would grant.
        tick();
        check("rst_in_ready", 32'(a_in_ready), 32'h0);
        check_out("rst1", 1'b0, 16'h0000, 2'd0);
        tick();
        check_out("rst2", 1'b0, 16'h0000, 2'd0);
        check("rst_b_in_ready", 32'(b_in_ready), 32'h0);

        // Idle after release, round-robin with nothing valid.
        reset = 1'b0;
        a_mode = 1'b1;
        #1;
        check("idle_in_ready", 32'(a_in_ready), 32'h0);
        tick();
        check_out("idle", 1'b0, 16'h0000, 2'd0);
        check("idle_in_ready2", 32'(a_in_ready), 32'h0);

        // Direct-mode streaming from source 2.
        a_mode = 1'b0; a_sel = 2'd2; a_in_valid = 4'b0100; a_out_ready = 1'b1;
        a_in_data[32 +: 16] = 16'hA5A5;
        #1;
        check("dir_in_ready", 32'(a_in_ready), 32'h4);
        tick();
        check_out("dir0", 1'b1, 16'hA5A5, 2'd2);
        a_in_data[32 +: 16] = 16'h5A5A;
        #1;
        check("dir_in_ready_full", 32'(a_in_ready), 32'h4);
        tick();
        check_out("dir1", 1'b1, 16'h5A5A, 2'd2);
        a_in_data[32 +: 16] = 16'h1234;
        tick();
        check_out("dir2", 1'b1, 16'h1234, 2'd2);
        a_in_valid = 4'b0000;
        tick();
        check_out("dir_drain", 1'b0, 16'h1234, 2'd2);

        // Backpressure: hold A5A5 for three stalled cycles, then 5A5A follows.
        a_in_valid = 4'b0100;
        a_in_data[32 +: 16] = 16'hA5A5;
        tick();
        check_out("bp_load", 1'b1, 16'hA5A5, 2'd2);
        a_out_ready = 1'b0;
        a_in_data[32 +: 16] = 16'h5A5A;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_in_ready", 32'(a_in_ready), 32'h0);
            tick();
            check_out("bp_hold", 1'b1, 16'hA5A5, 2'd2);
        end
        a_out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(a_in_ready), 32'h4);
        tick();
        check_out("bp_next", 1'b1, 16'h5A5A, 2'd2);
        a_in_valid = 4'b0000;
        tick();
        check_out("bp_drain", 1'b0, 16'h5A5A, 2'd2);

        // Round-robin fairness with all sources valid, showing wrap-around.
        a_mode = 1'b1; a_in_valid = 4'b1111;
        a_in_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        #1;
        check("rr_in_ready0", 32'(a_in_ready), 32'h1);
        tick();
        check_out("rr0", 1'b1, 16'h0000, 2'd0);
        check("rr_in_ready1", 32'(a_in_ready), 32'h2);
        tick();
        check_out("rr1", 1'b1, 16'h1111, 2'd1);
        tick();
        check_out("rr2", 1'b1, 16'h2222, 2'd2);
        tick();
        check_out("rr3", 1'b1, 16'h3333, 2'd3);
        tick();
        check_out("rr4", 1'b1, 16'h0000, 2'd0);
        a_in_valid = 4'b0000;
        tick();
        check_out("rr_drain", 1'b0, 16'h0000, 2'd0);

        // Sparse round-robin: pointer is 1, grant source 1 moves it to 2.
        a_in_valid = 4'b0010;
        tick();
        check_out("sp_src1", 1'b1, 16'h1111, 2'd1);
        a_in_valid = 4'b0001;
        #1;
        check("sp_wrap_in_ready", 32'(a_in_ready), 32'h1);
        tick();
        check_out("sp_src0", 1'b1, 16'h0000, 2'd0);
        // Pointer now 1: scan 1,2,3,0 picks source 3 over source 0.
        a_in_valid = 4'b1001;
        #1;
        check("sp_ptr1_in_ready", 32'(a_in_ready), 32'h8);
        tick();
        check_out("sp_src3", 1'b1, 16'h3333, 2'd3);
        check("sp_ptr0_in_ready", 32'(a_in_ready), 32'h1);

        // Mid-operation reset discards a held word.
        a_mode = 1'b0; a_sel = 2'd1; a_in_valid = 4'b0010;
        a_in_data[16 +: 16] = 16'hBEEF;
        tick();
        check_out("beef_load", 1'b1, 16'hBEEF, 2'd1);
        a_in_valid = 4'b0000; a_out_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(a_in_ready), 32'h0);
        tick();
        check_out("mid_rst", 1'b0, 16'h0000, 2'd0);
        reset = 1'b0;

        // Out-of-range select on the 3-source instance.
        b_mode = 1'b0; b_sel = 2'd3; b_in_valid = 3'b111;
        #1;
        check("bad_sel_in_ready", 32'(b_in_ready), 32'h0);
        tick();
        check("bad_sel_valid", 32'(b_out_valid), 32'h0);
        check("bad_sel_data", 32'(b_out_data), 32'h0);
        b_sel = 2'd2;
        #1;
        check("b_sel2_in_ready", 32'(b_in_ready), 32'h4);
        tick();
        check("b_sel2_valid", 32'(b_out_valid), 32'h1);
        check("b_sel2_data", 32'(b_out_data), 32'hC002);
        check("b_sel2_src", 32'(b_out_src), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
